// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width. The RTL
// and the testbench both import this package.
package serial_adder_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_ctrl_full_adder_cell.sv
// One-bit full adder, purely combinational.
// This is the only adder logic in the serial adder block.
// Ports:
//   a, b, cin : operand bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller. It adds two WIDTH-bit operands LSB first,
// one bit per clock, through a single shared full_adder_cell.
// Ports:
//   clk, reset    : system clock; synchronous active-high reset
//   start         : request, sampled only in IDLE
//   a, b, cin     : operands and carry-in, captured at the accepting edge
//   busy          : high while the adder is sequencing bits (RUN)
//   done          : one-cycle pulse once the result is valid (DONE)
//   sum, cout     : result {cout, sum} = a + b + cin
//   overflow      : signed overflow (carry into MSB ^ carry out of MSB)
module serial_adder_ctrl
    import serial_adder_defs::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic             msb_cin;
    logic             fa_sum, fa_cout;

    full_adder_cell u_fa (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            carry   <= 1'b0;
            msb_cin <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa     <= a;
                        opb     <= b;
                        carry   <= cin;
                        cnt     <= '0;
                        msb_cin <= 1'b0;
                        sum     <= '0;
                        cout    <= 1'b0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_cout;
                    sum   <= {fa_sum, sum[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        // Counter parks on LAST rather than wrapping; the next load clears it.
                        msb_cin <= carry;
                        cout    <= fa_cout;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Overflow is the XOR of two flops that are set on the final bit edge and
    // cleared together on load/reset, so it tracks the registered result exactly.
    assign overflow = msb_cin ^ cout;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;
    import serial_adder_defs::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, overflow;
    logic [W-1:0] sum;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_result(input string nm, input logic [W-1:0] s, input logic co, input logic ov);
        chk({nm, "_sum"}, 32'(sum), 32'(s));
        chk({nm, "_cout"}, 32'(cout), 32'(co));
        chk({nm, "_ovf"}, 32'(overflow), 32'(ov));
    endtask

    // Full operation with fixed timeline: accept at edge k, busy after k..k+7,
    // done after k+8, idle after k+9. Inputs are scrambled after acceptance.
    task automatic run_op(input vec_t v);
        int unsigned bad_cycles;
        bad_cycles = 0;
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk({v.name, "_busy_first"}, {busy, done}, 2'b10);
        for (int i = 1; i < int'(W); i++) begin
            tick();
            if (busy !== 1'b1 || done !== 1'b0) bad_cycles++;
        end
        chk({v.name, "_busy_window"}, bad_cycles, 0);
        tick();
        chk({v.name, "_done_pulse"}, {busy, done}, 2'b01);
        chk_result(v.name, v.s, v.co, v.ov);
        tick();
        chk({v.name, "_done_end"}, {busy, done}, 2'b00);
        chk({v.name, "_hold_sum"}, 32'(sum), 32'(v.s));
    endtask

    vec_t vecs[6];

    initial begin
        int unsigned spurious;

        vecs[0] = '{"zero",   8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{"ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{"7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{"a5_5a",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{"80_80",  8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{"ff_ff",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        tick();
        tick();
        chk("reset_flags", {busy, done}, 2'b00);
        chk_result("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0; start = 1'b0;
        tick();

        foreach (vecs[i]) run_op(vecs[i]);

        // start pulsed during RUN must be ignored
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("ign_busy_still", {busy, done}, 2'b10);
        tick();
        chk("ign_done", {busy, done}, 2'b01);
        chk_result("ign", 8'h80, 1'b0, 1'b1);
        tick();
        chk("ign_single_pulse", {busy, done}, 2'b00);

        // start held high through RUN and DONE: next op accepted on first IDLE edge
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        a = 8'hFF; b = 8'h01; cin = 1'b0;
        for (int i = 1; i < int'(W); i++) tick();
        tick();
        chk("held_done", {busy, done}, 2'b01);
        chk_result("held_first", 8'h46, 1'b0, 1'b0);
        tick();
        chk("held_idle", {busy, done}, 2'b00);
        tick();
        chk("held_reaccept", {busy, done}, 2'b10);
        start = 1'b0;
        for (int i = 1; i < int'(W); i++) tick();
        tick();
        chk("held2_done", {busy, done}, 2'b01);
        chk_result("held2", 8'h00, 1'b1, 1'b0);
        tick();

        // reset on the 4th RUN edge aborts the operation
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_flags", {busy, done}, 2'b00);
        chk_result("abort", 8'h00, 1'b0, 1'b0);
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) spurious++;
        end
        chk("abort_no_done", spurious, 0);
        run_op('{"after_abort", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
